// File: rtl/hmnoc_psum_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hmnoc_psum_pkg
//  Brief    : Shared mode encodings and the per-lane signed add with optional
//             saturation for the HMNOC vertical psum chain.
//  Revision : 1.0  initial release
// ============================================================================
package hmnoc_psum_pkg;

   // Per-stage operating mode; 2'b11 is decoded as BYPASS by the stage.
   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_ACCUM  = 2'b01,
      MODE_INJECT = 2'b10
   } psum_mode_e;

   // Widest lane the add helper supports.
   localparam int LANE_MAX = 32;

   // Signed add of two w-bit lanes held in the low bits of a and b.
   // Returns {overflow, result}; the result occupies the low w bits.
   // With sat set, an overflowing sum clamps to the most positive or most
   // negative w-bit value, otherwise the low w bits are kept (wrap).
   function automatic logic [LANE_MAX:0] lane_add(
      input logic [LANE_MAX-1:0] a,
      input logic [LANE_MAX-1:0] b,
      input int unsigned         w,
      input logic                sat
   );
      logic signed [LANE_MAX:0] ea;
      logic signed [LANE_MAX:0] eb;
      logic signed [LANE_MAX:0] sum;
      logic signed [LANE_MAX:0] top;
      logic [LANE_MAX-1:0]      max_v;
      logic [LANE_MAX-1:0]      min_v;
      logic [LANE_MAX-1:0]      mask;
      logic [LANE_MAX-1:0]      res;
      logic                     ovf;
      int unsigned              sh;
      sh    = LANE_MAX + 1 - w;
      // Sign-extend each operand from bit w-1 up to LANE_MAX+1 bits.
      ea    = $signed({1'b0, a} << sh) >>> sh;
      eb    = $signed({1'b0, b} << sh) >>> sh;
      sum   = ea + eb;
      // In range only when everything above bit w-2 is a pure sign copy.
      top   = sum >>> (w - 1);
      ovf   = (top != '0) && (top != '1);
      max_v = (LANE_MAX'(1) << (w - 1)) - LANE_MAX'(1);
      min_v = LANE_MAX'(1) << (w - 1);
      mask  = {LANE_MAX{1'b1}} >> (LANE_MAX - w);
      res   = sum[LANE_MAX-1:0] & mask;
      if (sat && ovf) begin
         res = sum[LANE_MAX] ? min_v : max_v;
      end
      return {ovf, res};
   endfunction

endpackage
`default_nettype wire

// File: rtl/hmnoc_psum_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hmnoc_psum_stage
//  Brief    : One hop of the psum chain: mode mux (bypass / accumulate /
//             inject), per-lane adders, elastic output FIFO and a sticky
//             overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module hmnoc_psum_stage
   import hmnoc_psum_pkg::*;
#(
   parameter int DATA_BITWIDTH = 16,
   parameter int X_dim         = 3,
   parameter int FIFO_DEPTH    = 4,
   parameter int SATURATE      = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [1:0]                     mode,
   input  logic                           up_valid,
   output logic                           up_ready,
   input  logic [DATA_BITWIDTH*X_dim-1:0] up_data,
   input  logic                           loc_valid,
   output logic                           loc_ready,
   input  logic [DATA_BITWIDTH*X_dim-1:0] loc_data,
   output logic                           dn_valid,
   input  logic                           dn_ready,
   output logic [DATA_BITWIDTH*X_dim-1:0] dn_data,
   output logic                           ovf_flag
);

   localparam int VEC_W = DATA_BITWIDTH * X_dim;
   localparam int AW    = $clog2(FIFO_DEPTH);

   logic [VEC_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             pop;
   logic             space;
   logic             push;
   logic             is_accum;
   logic [VEC_W-1:0] push_data;
   logic [VEC_W-1:0] sum_data;
   logic [X_dim-1:0] lane_ovf;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dn_valid = !empty;
   assign dn_data  = mem[rd_ptr[AW-1:0]];
   assign pop      = dn_valid & dn_ready;
   // A full FIFO can still take a push when the head leaves this cycle.
   assign space    = !full | pop;

   // Lane-wise sum of upstream and local vectors for ACCUM.
   for (genvar i = 0; i < X_dim; i++) begin : g_lane
      logic [LANE_MAX:0] lane_res;
      assign lane_res = lane_add(LANE_MAX'(up_data[i*DATA_BITWIDTH +: DATA_BITWIDTH]),
                                 LANE_MAX'(loc_data[i*DATA_BITWIDTH +: DATA_BITWIDTH]),
                                 DATA_BITWIDTH, (SATURATE != 0));
      assign sum_data[i*DATA_BITWIDTH +: DATA_BITWIDTH] = lane_res[DATA_BITWIDTH-1:0];
      assign lane_ovf[i] = lane_res[LANE_MAX];
      if (DATA_BITWIDTH < LANE_MAX) begin : g_pad
         logic pad_unused;
         assign pad_unused = ^lane_res[LANE_MAX-1:DATA_BITWIDTH];
      end
   end

   // Mode mux: readies are raised only when that input would be consumed,
   // and in ACCUM each side additionally needs its partner's valid.
   always_comb begin
      up_ready  = 1'b0;
      loc_ready = 1'b0;
      push      = 1'b0;
      is_accum  = 1'b0;
      push_data = up_data;
      case (mode)
         MODE_ACCUM: begin
            is_accum  = 1'b1;
            up_ready  = space & loc_valid;
            loc_ready = space & up_valid;
            push      = space & up_valid & loc_valid;
            push_data = sum_data;
         end
         MODE_INJECT: begin
            loc_ready = space;
            push      = space & loc_valid;
            push_data = loc_data;
         end
         default: begin
            up_ready  = space;
            push      = space & up_valid;
         end
      endcase
   end

   // FIFO storage and pointers; reset clears storage so the head reads 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Sticky overflow: any lane overflowing on an accumulating push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_flag <= 1'b0;
      end else if (push && is_accum && (|lane_ovf)) begin
         ovf_flag <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hmnoc_psum_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hmnoc_psum_chain
//  Brief    : Vertical partial-sum chain across N_CLUSTER stacked clusters,
//             feeding the bottom psum GLB write port and counting tiles.
//  Revision : 1.0  initial release
// ============================================================================
module hmnoc_psum_chain
   import hmnoc_psum_pkg::*;
#(
   parameter int DATA_BITWIDTH = 16,
   parameter int X_dim         = 3,
   parameter int N_CLUSTER     = 4,
   parameter int FIFO_DEPTH    = 4,
   parameter int SATURATE      = 1,
   parameter int TILE_BITWIDTH = 10
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [2*N_CLUSTER-1:0]                   mode,
   input  logic [TILE_BITWIDTH-1:0]                 tile_len,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [DATA_BITWIDTH*X_dim-1:0]           in_data,
   input  logic [N_CLUSTER-1:0]                     loc_valid,
   output logic [N_CLUSTER-1:0]                     loc_ready,
   input  logic [N_CLUSTER*X_dim*DATA_BITWIDTH-1:0] loc_data,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [DATA_BITWIDTH*X_dim-1:0]           out_data,
   output logic                                     tile_done,
   output logic [N_CLUSTER-1:0]                     ovf_flag
);

   localparam int VEC_W = DATA_BITWIDTH * X_dim;

   logic                     xfer;
   logic                     last;
   logic [TILE_BITWIDTH-1:0] count;

   // Each hop owns its link signals so the ready chain is made of distinct
   // nets rather than bits of one shared vector.
   for (genvar k = 0; k < N_CLUSTER; k++) begin : g_stage
      logic             up_valid_s;
      logic             up_ready_s;
      logic [VEC_W-1:0] up_data_s;
      logic             dn_valid_s;
      logic             dn_ready_s;
      logic [VEC_W-1:0] dn_data_s;

      if (k == 0) begin : g_head
         assign up_valid_s = in_valid;
         assign up_data_s  = in_data;
         assign in_ready   = up_ready_s;
      end else begin : g_link
         assign up_valid_s = g_stage[k-1].dn_valid_s;
         assign up_data_s  = g_stage[k-1].dn_data_s;
      end

      if (k == N_CLUSTER - 1) begin : g_tail
         assign dn_ready_s = out_ready;
         assign out_valid  = dn_valid_s;
         assign out_data   = dn_data_s;
      end else begin : g_mid
         assign dn_ready_s = g_stage[k+1].up_ready_s;
      end

      hmnoc_psum_stage #(
         .DATA_BITWIDTH (DATA_BITWIDTH),
         .X_dim         (X_dim),
         .FIFO_DEPTH    (FIFO_DEPTH),
         .SATURATE      (SATURATE)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .mode      (mode[2*k +: 2]),
         .up_valid  (up_valid_s),
         .up_ready  (up_ready_s),
         .up_data   (up_data_s),
         .loc_valid (loc_valid[k]),
         .loc_ready (loc_ready[k]),
         .loc_data  (loc_data[k*VEC_W +: VEC_W]),
         .dn_valid  (dn_valid_s),
         .dn_ready  (dn_ready_s),
         .dn_data   (dn_data_s),
         .ovf_flag  (ovf_flag[k])
      );
   end

   // tile_done is aligned with the transfer that completes the tile.
   assign xfer      = out_valid & out_ready;
   assign last      = (tile_len != '0) && (count == tile_len - 1'b1);
   assign tile_done = xfer & last;

   // Tile length counter; held at zero while tile_len is zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (tile_len == '0) begin
         count <= '0;
      end else if (xfer) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hmnoc_psum_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hmnoc_psum_chain
//  Brief    : Scoreboard bench for hmnoc_psum_chain; a saturating and a
//             wrapping instance share all stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hmnoc_psum_chain;

   localparam int DW = 16;
   localparam int XD = 3;
   localparam int NC = 4;
   localparam int TW = 10;
   localparam int VW = DW * XD;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [2*NC-1:0]   mode;
   logic [TW-1:0]     tile_len;
   logic              in_valid;
   logic [VW-1:0]     in_data;
   logic [NC-1:0]     loc_valid;
   logic [NC*VW-1:0]  loc_data;
   logic              rand_rdy;
   logic              fix_rdy;
   logic              rnd_bit = 1'b1;
   wire               out_ready;
   wire               in_ready,  in_ready_w;
   wire  [NC-1:0]     loc_ready, loc_ready_w;
   wire               out_valid, out_valid_w;
   wire  [VW-1:0]     out_data,  out_data_w;
   wire               tile_done, tile_done_w;
   wire  [NC-1:0]     ovf_flag,  ovf_flag_w;

   assign out_ready = rand_rdy ? rnd_bit : fix_rdy;

   hmnoc_psum_chain #(.SATURATE(1)) dut (
      .clk(clk), .reset(reset), .mode(mode), .tile_len(tile_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .loc_valid(loc_valid), .loc_ready(loc_ready), .loc_data(loc_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .tile_done(tile_done), .ovf_flag(ovf_flag)
   );

   hmnoc_psum_chain #(.SATURATE(0)) dut_w (
      .clk(clk), .reset(reset), .mode(mode), .tile_len(tile_len),
      .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
      .loc_valid(loc_valid), .loc_ready(loc_ready_w), .loc_data(loc_data),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
      .tile_done(tile_done_w), .ovf_flag(ovf_flag_w)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [VW-1:0] sat;
      logic [VW-1:0] wrap;
      int            acc;
      int            lat;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   bad    = 0;
   int   cyc    = 0;
   int   pulses = 0;
   bit   inj_leak = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1);
   end

   function automatic logic [VW-1:0] v(input int a, input int b, input int c);
      return {c[15:0], b[15:0], a[15:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // Drive one vector on the upstream port (src<0) or on local port src,
   // pushing the expected output when the handshake is seen.
   task automatic send(input int src, input logic [VW-1:0] d, input logic [VW-1:0] es,
                       input logic [VW-1:0] ew, input int lat);
      int n   = 0;
      bit got = 1'b0;
      if (src < 0) begin
         in_valid = 1'b1;
         in_data  = d;
      end else begin
         loc_valid[src]           = 1'b1;
         loc_data[src*VW +: VW]   = d;
      end
      while (!got && n < 200) begin
         @(negedge clk);
         if (src < 0 ? in_ready : loc_ready[src]) begin
            got = 1'b1;
            exp_q.push_back('{es, ew, cyc + 1, lat});
         end
         if (src >= 0 && in_valid && in_ready) inj_leak = 1'b1;
         n++;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL send_accept: got no ready in 200 cycles want ready");
      end
      @(posedge clk);
      #1;
      if (src < 0) in_valid = 1'b0;
      else loc_valid[src] = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every output transfer and models the
   // tile counter and output hold under backpressure.
   initial begin : monitor
      exp_t          e;
      bit            prev_stall = 1'b0;
      logic [VW-1:0] prev_data  = '0;
      int            tcnt = 0;
      int            tl;
      bit            exp_done;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_stall = 1'b0;
            tcnt       = 0;
         end else begin
            tl = int'(tile_len);
            if (prev_stall) check("hold_data", 64'(out_data), 64'(prev_data));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_out: got %0h want no transfer", out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("out_sat", 64'(out_data), 64'(e.sat));
                  check("out_wrap_valid", 64'(out_valid_w), 64'd1);
                  check("out_wrap", 64'(out_data_w), 64'(e.wrap));
                  if (e.lat != 0) check("latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
               end
               exp_done = (tl != 0) && (tcnt == tl - 1);
               check("tile_done", 64'(tile_done), 64'(exp_done));
               if (tile_done) pulses++;
               tcnt = (tl == 0 || exp_done) ? 0 : tcnt + 1;
            end else begin
               check("tile_idle", 64'(tile_done), 64'd0);
               if (tl == 0) tcnt = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
         end
      end
   end

   initial begin : stim
      int acc;
      mode      = '0;
      tile_len  = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      loc_valid = '0;
      loc_data  = '0;
      rand_rdy  = 1'b0;
      fix_rdy   = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_tile_done", 64'(tile_done), 64'd0);
      check("rst_ovf",       64'(ovf_flag),  64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_loc_ready", 64'(loc_ready), 64'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      // All BYPASS: single vector latency, then 8 back-to-back
      send(-1, v(1, 2, 3), v(1, 2, 3), v(1, 2, 3), 4);
      drain("bypass1");
      for (int i = 0; i < 8; i++) send(-1, v(i, i + 1, i + 2), v(i, i + 1, i + 2), v(i, i + 1, i + 2), 4);
      drain("bypass8");

      // All ACCUM with loc k = {k,k,k}: 1 + 0 + 1 + 2 + 3 = 7
      mode = 8'h55;
      for (int k = 0; k < NC; k++) loc_data[k*VW +: VW] = v(k, k, k);
      loc_valid = 4'hF;
      for (int i = 0; i < 3; i++) send(-1, v(1, 1, 1), v(7, 7, 7), v(7, 7, 7), 4);
      drain("accum");
      check("accum_ovf", 64'(ovf_flag), 64'd0);

      // Stage 2 local withheld: stages 0 and 1 fill, then in_ready drops
      loc_valid = 4'b1011;
      in_valid  = 1'b1;
      in_data   = v(1, 1, 1);
      acc       = 0;
      repeat (20) begin
         @(negedge clk);
         if (in_ready) begin
            acc++;
            exp_q.push_back('{v(7, 7, 7), v(7, 7, 7), cyc + 1, 0});
         end
      end
      check("stall_accepts", 64'(acc), 64'd8);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      loc_valid = 4'hF;
      drain("stall");
      loc_valid = '0;

      // Stage 0 INJECT, others BYPASS; upstream never accepted
      mode     = 8'h02;
      in_valid = 1'b1;
      in_data  = v(9, 9, 9);
      inj_leak = 1'b0;
      for (int i = 0; i < 3; i++) send(0, v(5, 5, 5), v(5, 5, 5), v(5, 5, 5), 4);
      drain("inject");
      check("inject_in_ready", 64'(inj_leak), 64'd0);
      in_valid = 1'b0;

      // Overflow: lane0 7FFF+1, lane1 8000+FFFF, lane2 5+(-3)
      mode      = 8'h55;
      loc_data  = '0;
      loc_data[0 +: VW] = v(16'h0001, 16'hFFFF, 16'hFFFD);
      loc_valid = 4'hF;
      send(-1, v(16'h7FFF, 16'h8000, 16'h0005), v(16'h7FFF, 16'h8000, 16'h0002),
           v(16'h8000, 16'h7FFF, 16'h0002), 4);
      drain("ovf");
      check("ovf_sat",  64'(ovf_flag),   64'd1);
      check("ovf_wrap", 64'(ovf_flag_w), 64'd1);
      loc_data = '0;
      send(-1, v(10, 20, 30), v(10, 20, 30), v(10, 20, 30), 0);
      drain("ovf_after");
      check("ovf_sticky_sat",  64'(ovf_flag),   64'd1);
      check("ovf_sticky_wrap", 64'(ovf_flag_w), 64'd1);
      loc_valid = '0;

      // Tile counting with random backpressure: pulses on transfers 3 and 6
      mode     = 8'h00;
      tile_len = 10'd3;
      pulses   = 0;
      rand_rdy = 1'b1;
      for (int i = 0; i < 7; i++) send(-1, v(i, 2 * i, 3 * i), v(i, 2 * i, 3 * i), v(i, 2 * i, 3 * i), 0);
      drain("tile");
      check("tile_pulses", 64'(pulses), 64'd2);
      tile_len = 10'd0;
      pulses   = 0;
      for (int i = 0; i < 4; i++) send(-1, v(i, i, i), v(i, i, i), v(i, i, i), 0);
      drain("tile_off");
      rand_rdy = 1'b0;
      check("tile_off_pulses", 64'(pulses), 64'd0);
      check("ovf_after_tile", 64'(ovf_flag), 64'd1);

      // Reset with vectors in flight
      fix_rdy = 1'b0;
      for (int i = 0; i < 3; i++) send(-1, v(40 + i, 41, 42), v(40 + i, 41, 42), v(40 + i, 41, 42), 0);
      repeat (2) @(negedge clk);
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_data",  64'(out_data),  64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b1;
      fix_rdy = 1'b1;
      check("post_rst_ovf",   64'(ovf_flag),   64'd0);
      check("post_rst_ovf_w", 64'(ovf_flag_w), 64'd0);
      send(-1, v(9, 8, 7), v(9, 8, 7), v(9, 8, 7), 4);
      drain("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
